// File: rtl/bootrom_arbiter.sv
// Purpose: shares the single-ported boot RAM between port A (CPU) and port B (debug loader), round-robin, A write-protect.
// Latency: request seen in IDLE at cycle N -> RAM access at N+1 -> ack (and read data) at N+2; max one access per 3 cycles.
// Backpressure: requesters hold req and payload until their ack pulse; requests are not looked at outside IDLE.
module bootrom_arbiter #(
  parameter int BITDEPTH = 9
) (
  input  logic                clk,
  input  logic                resetn,
  // port A: CPU slave path
  input  logic                a_req_i,
  input  logic                a_rwn_i,
  input  logic [BITDEPTH-1:0] a_addr_i,
  input  logic [7:0]          a_wdata_i,
  output logic                a_ack_o,
  output logic                a_err_o,
  output logic [7:0]          a_rdata_o,
  // port B: debug loader, never write-protected
  input  logic                b_req_i,
  input  logic                b_rwn_i,
  input  logic [BITDEPTH-1:0] b_addr_i,
  input  logic [7:0]          b_wdata_i,
  output logic                b_ack_o,
  output logic [7:0]          b_rdata_o,
  // write protect for port A
  input  logic                wp_i,
  // boot RAM side
  output logic                ram_req_o,
  output logic                ram_rwn_o,
  output logic [BITDEPTH-1:0] ram_addr_o,
  output logic [7:0]          ram_wdata_o,
  output logic                ram_datawr_valid_o,
  input  logic [7:0]          ram_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Port encoding for sel/last_grant: 0 = A, 1 = B.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  state_t              state_q, state_d;
  logic                sel_q, sel_d;
  logic                last_q, last_d;
  logic [BITDEPTH-1:0] addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                rwn_q, rwn_d;
  logic                wp_q, wp_d;
  logic                grant_b;
  logic                blocked;

  // An A write captured while write protect was set never reaches the RAM.
  assign blocked = (sel_q == PORT_A) && !rwn_q && wp_q;

  // B wins when it is alone, or when both ask and A had the previous grant.
  assign grant_b = b_req_i && (!a_req_i || (last_q == PORT_A));

  // State and captured request; last_grant resets to B so A wins the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      sel_q   <= PORT_A;
      last_q  <= PORT_B;
      addr_q  <= '0;
      wdata_q <= '0;
      rwn_q   <= 1'b1;
      wp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rwn_q   <= rwn_d;
      wp_q    <= wp_d;
    end
  end

  // Next state, grant capture and all outputs (outputs are decoded from the state register).
  always_comb begin
    state_d            = state_q;
    sel_d              = sel_q;
    last_d             = last_q;
    addr_d             = addr_q;
    wdata_d            = wdata_q;
    rwn_d              = rwn_q;
    wp_d               = wp_q;
    a_ack_o            = 1'b0;
    a_err_o            = 1'b0;
    a_rdata_o          = 8'h00;
    b_ack_o            = 1'b0;
    b_rdata_o          = 8'h00;
    ram_req_o          = 1'b0;
    ram_rwn_o          = 1'b1;
    ram_addr_o         = '0;
    ram_wdata_o        = 8'h00;
    ram_datawr_valid_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (a_req_i || b_req_i) begin
          sel_d   = grant_b;
          last_d  = grant_b;
          addr_d  = grant_b ? b_addr_i  : a_addr_i;
          wdata_d = grant_b ? b_wdata_i : a_wdata_i;
          rwn_d   = grant_b ? b_rwn_i   : a_rwn_i;
          wp_d    = wp_i;
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        ram_req_o          = 1'b1;
        ram_rwn_o          = rwn_q;
        ram_addr_o         = addr_q;
        ram_wdata_o        = wdata_q;
        ram_datawr_valid_o = !rwn_q && !blocked;
        state_d            = ST_RESP;
      end

      ST_RESP: begin
        // RAM read data is registered, so it is valid in this cycle.
        if (sel_q == PORT_A) begin
          a_ack_o   = 1'b1;
          a_err_o   = blocked;
          a_rdata_o = ram_rdata_i;
        end else begin
          b_ack_o   = 1'b1;
          b_rdata_o = ram_rdata_i;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bootrom_arbiter.sv
module tb_bootrom_arbiter;

  localparam int BD = 9;

  logic          clk = 1'b0;
  logic          resetn;
  logic          a_req_i, a_rwn_i, b_req_i, b_rwn_i, wp_i;
  logic [BD-1:0] a_addr_i, b_addr_i;
  logic [7:0]    a_wdata_i, b_wdata_i;
  logic          a_ack_o, a_err_o, b_ack_o;
  logic [7:0]    a_rdata_o, b_rdata_o;
  logic          ram_req_o, ram_rwn_o, ram_datawr_valid_o;
  logic [BD-1:0] ram_addr_o;
  logic [7:0]    ram_wdata_o, ram_rdata_i;

  always #5 clk = ~clk;

  bootrom_arbiter #(.BITDEPTH(BD)) dut (
    .clk(clk), .resetn(resetn),
    .a_req_i(a_req_i), .a_rwn_i(a_rwn_i), .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i),
    .a_ack_o(a_ack_o), .a_err_o(a_err_o), .a_rdata_o(a_rdata_o),
    .b_req_i(b_req_i), .b_rwn_i(b_rwn_i), .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i),
    .b_ack_o(b_ack_o), .b_rdata_o(b_rdata_o),
    .wp_i(wp_i),
    .ram_req_o(ram_req_o), .ram_rwn_o(ram_rwn_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_datawr_valid_o(ram_datawr_valid_o),
    .ram_rdata_i(ram_rdata_i)
  );

  // Boot RAM device: single port, registered read.
  logic [7:0] mem [0:511];
  logic [7:0] ram_rdata_q;
  assign ram_rdata_i = ram_rdata_q;

  function automatic logic [7:0] init_val(int i);
    if (i == 16) return 8'h5A;
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = init_val(i);
    ram_rdata_q = 8'h00;
    forever begin
      @(posedge clk);
      if (ram_req_o) begin
        ram_rdata_q <= mem[ram_addr_o];
        if (ram_datawr_valid_o) mem[ram_addr_o] = ram_wdata_o;
      end
    end
  end

  // Reference model: expected RAM contents and arbitration history.
  logic [7:0] ref_mem [0:511];
  bit         last_b;
  int         n_checks = 0;
  int         n_fail   = 0;

  // Observations of one run_pair call.
  int         o_la, o_lb, o_na, o_nb, o_nst, o_rqc;
  logic [7:0] o_rda, o_rdb;
  logic       o_erra;
  logic [8:0] o_rqaddr;

  task automatic model_access(input bit pb, input bit rwn, input logic [8:0] addr,
                              input logic [7:0] wd, input bit wp,
                              output logic [7:0] rd, output bit err, output int st);
    bit blk;
    blk = !pb && !rwn && wp;
    err = blk;
    st  = (!rwn && !blk) ? 1 : 0;
    rd  = ref_mem[addr];
    if (st == 1) ref_mem[addr] = wd;
  endtask

  task automatic apply_reset();
    resetn = 1'b0; a_req_i = 0; b_req_i = 0; a_rwn_i = 1; b_rwn_i = 1;
    a_addr_i = '0; b_addr_i = '0; a_wdata_i = 0; b_wdata_i = 0; wp_i = 0;
    #12;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    last_b = 1'b1;
  endtask

  // Drive requests from posedge+1, drop each one in its ack cycle, observe 12 cycles.
  task automatic run_pair(input bit ra, input bit rb,
                          input bit ar, input logic [8:0] aa, input logic [7:0] aw,
                          input bit br, input logic [8:0] ba, input logic [7:0] bw,
                          input bit wp);
    wp_i = wp;
    a_req_i = ra; a_rwn_i = ar; a_addr_i = aa; a_wdata_i = aw;
    b_req_i = rb; b_rwn_i = br; b_addr_i = ba; b_wdata_i = bw;
    o_la = -1; o_lb = -1; o_na = 0; o_nb = 0; o_nst = 0; o_rqc = -1;
    o_rda = 0; o_rdb = 0; o_erra = 0; o_rqaddr = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (ram_req_o && o_rqc < 0) begin o_rqc = c; o_rqaddr = ram_addr_o; end
      if (ram_datawr_valid_o) o_nst++;
      if (a_ack_o) begin
        o_na++;
        if (o_la < 0) begin o_la = c; o_rda = a_rdata_o; o_erra = a_err_o; end
        a_req_i = 0;
      end
      if (b_ack_o) begin
        o_nb++;
        if (o_lb < 0) begin o_lb = c; o_rdb = b_rdata_o; end
        b_req_i = 0;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; a_req_i = 0; b_req_i = 0; a_rwn_i = 1; b_rwn_i = 1;
    a_addr_i = '0; b_addr_i = '0; a_wdata_i = 0; b_wdata_i = 0; wp_i = 0;
    #12;
    n_checks++;
    if ({ram_req_o, ram_datawr_valid_o, ram_rwn_o, a_ack_o, b_ack_o, a_err_o} !== 6'b001000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 001000",
               {ram_req_o, ram_datawr_valid_o, ram_rwn_o, a_ack_o, b_ack_o, a_err_o});
    end
    n_checks++;
    if ({ram_addr_o, ram_wdata_o} !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got addr %h wdata %h want 0", ram_addr_o, ram_wdata_o);
    end
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    last_b = 1'b1;
  endtask

  task automatic test_single_read();
    logic [7:0] rd; bit err; int st;
    model_access(1'b0, 1'b1, 9'h010, 8'h00, 1'b0, rd, err, st);
    run_pair(1, 0, 1, 9'h010, 8'h00, 1, 9'h0, 8'h0, 0);
    last_b = 1'b0;
    n_checks++;
    if (o_rqc !== 1 || o_rqaddr !== 9'h010) begin
      n_fail++; $display("FAIL a_read_access: got cycle %0d addr %h want 1 010", o_rqc, o_rqaddr);
    end
    n_checks++;
    if (o_la !== 2 || o_na !== 1 || o_nb !== 0) begin
      n_fail++; $display("FAIL a_read_ack: got lat %0d acks %0d/%0d want 2 1/0", o_la, o_na, o_nb);
    end
    n_checks++;
    if (o_rda !== 8'h5A || rd !== 8'h5A) begin
      n_fail++; $display("FAIL a_read_data: got %h want 5a", o_rda);
    end
  endtask

  task automatic test_b_write_read();
    logic [7:0] rd; bit err; int st;
    model_access(1'b1, 1'b0, 9'h1FF, 8'hC3, 1'b0, rd, err, st);
    run_pair(0, 1, 1, 9'h0, 8'h0, 0, 9'h1FF, 8'hC3, 0);
    n_checks++;
    if (o_nst !== 1 || o_lb !== 2 || o_nb !== 1 || o_na !== 0) begin
      n_fail++; $display("FAIL b_write: got strobes %0d lat %0d acks %0d/%0d want 1 2 1/0",
                         o_nst, o_lb, o_nb, o_na);
    end
    model_access(1'b1, 1'b1, 9'h1FF, 8'h00, 1'b0, rd, err, st);
    run_pair(0, 1, 1, 9'h0, 8'h0, 1, 9'h1FF, 8'h00, 0);
    last_b = 1'b1;
    n_checks++;
    if (o_rdb !== rd || o_lb !== 2 || o_nb !== 1 || o_nst !== 0) begin
      n_fail++; $display("FAIL b_readback: got %h lat %0d acks %0d want %h 2 1", o_rdb, o_lb, o_nb, rd);
    end
  endtask

  task automatic test_back_to_back();
    int   cyc [4];
    bit   prt [4];
    int   n, both;
    logic [7:0] rda, rdb;
    apply_reset();
    n = 0; both = 0;
    a_req_i = 1; a_rwn_i = 1; a_addr_i = 9'h030;
    b_req_i = 1; b_rwn_i = 1; b_addr_i = 9'h040;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (a_ack_o && b_ack_o) both++;
      if ((a_ack_o || b_ack_o) && n < 4) begin
        cyc[n] = c; prt[n] = b_ack_o;
        if (a_ack_o) rda = a_rdata_o; else rdb = b_rdata_o;
        n++;
      end
    end
    a_req_i = 0; b_req_i = 0;
    last_b = 1'b1;
    n_checks++;
    if (n !== 4 || both !== 0) begin
      n_fail++; $display("FAIL rr_count: got %0d acks %0d overlaps want 4 0", n, both);
    end
    for (int k = 0; k < 4 && k < n; k++) begin
      n_checks++;
      if (cyc[k] !== 2 + 3 * k || prt[k] !== k[0]) begin
        n_fail++; $display("FAIL rr_order[%0d]: got cycle %0d port %0d want %0d %0d",
                           k, cyc[k], prt[k], 2 + 3 * k, k[0]);
      end
    end
    n_checks++;
    if (rda !== ref_mem[9'h030] || rdb !== ref_mem[9'h040]) begin
      n_fail++; $display("FAIL rr_data: got %h %h want %h %h", rda, rdb, ref_mem[9'h030], ref_mem[9'h040]);
    end
  endtask

  task automatic test_write_protect();
    logic [7:0] rd, old; bit err; int st;
    old = ref_mem[9'h020];
    model_access(1'b0, 1'b0, 9'h020, 8'h77, 1'b1, rd, err, st);
    run_pair(1, 0, 0, 9'h020, 8'h77, 1, 9'h0, 8'h0, 1);
    last_b = 1'b0;
    n_checks++;
    if (o_nst !== 0 || o_la !== 2 || o_erra !== 1'b1 || !err) begin
      n_fail++; $display("FAIL wp_block: got strobes %0d lat %0d err %b want 0 2 1", o_nst, o_la, o_erra);
    end
    run_pair(1, 0, 1, 9'h020, 8'h00, 1, 9'h0, 8'h0, 0);
    n_checks++;
    if (o_rda !== old || o_erra !== 1'b0) begin
      n_fail++; $display("FAIL wp_old_value: got %h err %b want %h 0", o_rda, o_erra, old);
    end
    model_access(1'b1, 1'b0, 9'h020, 8'h99, 1'b1, rd, err, st);
    run_pair(0, 1, 1, 9'h0, 8'h0, 0, 9'h020, 8'h99, 1);
    n_checks++;
    if (o_nst !== 1 || o_nb !== 1) begin
      n_fail++; $display("FAIL wp_b_write: got strobes %0d acks %0d want 1 1", o_nst, o_nb);
    end
    run_pair(1, 0, 1, 9'h020, 8'h00, 1, 9'h0, 8'h0, 0);
    last_b = 1'b0;
    n_checks++;
    if (o_rda !== 8'h99) begin
      n_fail++; $display("FAIL wp_b_readback: got %h want 99", o_rda);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [7:0] old; int nb;
    old = ref_mem[9'h050];
    b_req_i = 1; b_rwn_i = 0; b_addr_i = 9'h050; b_wdata_i = ~old;
    @(posedge clk); #1;
    n_checks++;
    if (ram_datawr_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL mid_access_strobe: got %b want 1", ram_datawr_valid_o);
    end
    resetn = 1'b0; #1;
    n_checks++;
    if (ram_req_o !== 1'b0 || ram_datawr_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got req %b strobe %b want 0 0", ram_req_o, ram_datawr_valid_o);
    end
    b_req_i = 0;
    @(negedge clk); resetn = 1'b1;
    last_b = 1'b1;
    nb = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (b_ack_o || a_ack_o) nb++;
    end
    n_checks++;
    if (nb !== 0) begin
      n_fail++; $display("FAIL mid_reset_ack: got %0d acks want 0", nb);
    end
    run_pair(1, 0, 1, 9'h050, 8'h00, 1, 9'h0, 8'h0, 0);
    last_b = 1'b0;
    n_checks++;
    if (o_rda !== old || o_la !== 2) begin
      n_fail++; $display("FAIL mid_reset_ram: got %h lat %0d want %h 2", o_rda, o_la, old);
    end
  endtask

  task automatic test_reassert();
    int acks, c1, c2;
    logic [7:0] rd1, rd2;
    acks = 0; c1 = -1; c2 = -1; rd1 = 0; rd2 = 0;
    a_req_i = 1; a_rwn_i = 1; a_addr_i = 9'h060;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (a_ack_o) begin
        acks++;
        if (acks == 1) begin c1 = c; rd1 = a_rdata_o; end
        else begin c2 = c; rd2 = a_rdata_o; end
        a_req_i = 0;
      end else if (acks == 1 && c == c1 + 1) begin
        a_req_i = 1; a_addr_i = 9'h061;
      end
    end
    a_req_i = 0;
    last_b = 1'b0;
    n_checks++;
    if (acks !== 2 || c1 !== 2 || c2 !== 5) begin
      n_fail++; $display("FAIL reassert_acks: got %0d at %0d,%0d want 2 at 2,5", acks, c1, c2);
    end
    n_checks++;
    if (rd1 !== ref_mem[9'h060] || rd2 !== ref_mem[9'h061]) begin
      n_fail++; $display("FAIL reassert_data: got %h %h want %h %h", rd1, rd2, ref_mem[9'h060], ref_mem[9'h061]);
    end
  endtask

  task automatic test_random();
    bit ra, rb, ar, br, wp, first_b;
    logic [8:0] aa, ba;
    logic [7:0] aw, bw, rda, rdb;
    bit ea, eb;
    int sa, sb, ela, elb;
    for (int it = 0; it < 40; it++) begin
      ra = 1'($urandom); rb = 1'($urandom);
      if (!ra && !rb) ra = 1;
      ar = 1'($urandom); br = 1'($urandom); wp = 1'($urandom);
      aa = 9'h100 + 9'($urandom % 4); ba = 9'h100 + 9'($urandom % 4);
      aw = 8'($urandom); bw = 8'($urandom);
      first_b = (ra && rb) ? !last_b : rb;
      sa = 0; sb = 0; ea = 0; rda = 0; rdb = 0;
      if (first_b) begin
        model_access(1'b1, br, ba, bw, wp, rdb, eb, sb);
        if (ra) model_access(1'b0, ar, aa, aw, wp, rda, ea, sa);
      end else begin
        model_access(1'b0, ar, aa, aw, wp, rda, ea, sa);
        if (rb) model_access(1'b1, br, ba, bw, wp, rdb, eb, sb);
      end
      ela = !ra ? -1 : (first_b ? 5 : 2);
      elb = !rb ? -1 : (first_b ? 2 : 5);
      last_b = (ra && rb) ? !first_b : rb;
      run_pair(ra, rb, ar, aa, aw, br, ba, bw, wp);
      n_checks++;
      if (o_la !== ela || o_lb !== elb || o_na !== int'(ra) || o_nb !== int'(rb)) begin
        n_fail++; $display("FAIL rand_arb[%0d]: got A %0d/%0d B %0d/%0d want A %0d/%0d B %0d/%0d",
                           it, o_la, o_na, o_lb, o_nb, ela, ra, elb, rb);
      end
      n_checks++;
      if (o_nst !== sa + sb) begin
        n_fail++; $display("FAIL rand_strobes[%0d]: got %0d want %0d", it, o_nst, sa + sb);
      end
      if (ra) begin
        n_checks++;
        if (o_erra !== ea || (ar && o_rda !== rda)) begin
          n_fail++; $display("FAIL rand_a[%0d]: got err %b data %h want %b %h", it, o_erra, o_rda, ea, rda);
        end
      end
      if (rb && br) begin
        n_checks++;
        if (o_rdb !== rdb) begin
          n_fail++; $display("FAIL rand_b[%0d]: got data %h want %h", it, o_rdb, rdb);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
    last_b = 1'b1;
    test_reset();
    test_single_read();
    test_b_write_read();
    test_back_to_back();
    test_write_protect();
    test_reset_mid_access();
    test_reassert();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
